// File: rtl/audio_src_scheduler.sv
// Round-robin scheduler that shares one stereo audio output among N_SRC
// sample producers. It buffers one sample per source, makes at most one
// write per audio_ready window, and counts frames that end without a write.
module audio_src_scheduler #(
  parameter int unsigned AUDIO_BITS = 12,
  parameter int unsigned N_SRC      = 2,
  parameter int unsigned UCNT_W     = 16
) (
  input  logic                            clk,
  input  logic                            aclr,
  input  logic [N_SRC-1:0]                src_valid,
  input  logic [N_SRC*2*AUDIO_BITS-1:0]   src_sample,
  output logic [N_SRC-1:0]                src_ack,
  input  logic                            mute,
  input  logic                            audio_ready,
  output logic                            audio_wreq,
  output logic [2*AUDIO_BITS-1:0]         audio_sample,
  output logic [$clog2(N_SRC)-1:0]        grant_id,
  output logic [UCNT_W-1:0]               underrun_count
);

  localparam int unsigned SW  = 2 * AUDIO_BITS;
  localparam int unsigned IDW = $clog2(N_SRC);

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_WAIT_DROP = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  wreq_d;
  logic                  grant_fire;

  logic [SW-1:0]         sample_buf [N_SRC];
  logic [N_SRC-1:0]      buf_full;
  logic [IDW-1:0]        last_grant;
  logic [AUDIO_BITS-1:0] frame_cnt;
  logic                  wrote;
  logic                  frame_last;

  logic                  pick_found;
  logic [IDW-1:0]        pick_idx;
  int unsigned           cand;

  // A source may hand over a sample only while its buffer is empty and not in reset.
  assign src_ack    = src_valid & ~buf_full & {N_SRC{~aclr}};
  assign frame_last = (frame_cnt == '1);

  // Round-robin pick: first full buffer after the last granted source.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      cand = (32'(last_grant) + k) % N_SRC;
      if (!pick_found && buf_full[IDW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDW'(cand);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and write request: one grant per ready window, then wait for ready to drop.
  always_comb begin
    state_d    = state_q;
    wreq_d     = 1'b0;
    grant_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (audio_ready && pick_found) begin
          grant_fire = 1'b1;
          wreq_d     = 1'b1;
          state_d    = S_WAIT_DROP;
        end
      end
      S_WAIT_DROP: begin
        if (!audio_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sample buffers, output registers, frame timer and underrun counter.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        sample_buf[i] <= '0;
      end
      buf_full       <= '0;
      last_grant     <= IDW'(N_SRC - 1);
      audio_wreq     <= 1'b0;
      audio_sample   <= '0;
      grant_id       <= '0;
      frame_cnt      <= '0;
      wrote          <= 1'b0;
      underrun_count <= '0;
    end else begin
      // A granted buffer was full, so it never acks on the same edge.
      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (src_valid[i] && src_ack[i]) begin
          sample_buf[i] <= src_sample[i*SW +: SW];
          buf_full[i]   <= 1'b1;
        end
      end

      audio_wreq <= wreq_d;
      if (grant_fire) begin
        buf_full[pick_idx] <= 1'b0;
        audio_sample       <= mute ? '0 : sample_buf[pick_idx];
        grant_id           <= pick_idx;
        last_grant         <= pick_idx;
      end

      frame_cnt <= frame_cnt + AUDIO_BITS'(1);
      if (frame_last) begin
        if (!wrote && !grant_fire && (underrun_count != '1)) begin
          underrun_count <= underrun_count + UCNT_W'(1);
        end
        wrote <= grant_fire;
      end else if (grant_fire) begin
        wrote <= 1'b1;
      end
    end
  end

endmodule
